axi2mem_r_chan_drv: RTL
=======================

# axi2mem_r_chan_drv

Read-response driver for the axi2mem bridge. It pops 64-bit read beats from the EXT-side read pop interface of the transaction unit and presents them on the AXI R channel. It takes a per-burst command (ID, length) from the AR path, generates `r_last` from its own beat counter, and checks the data-side ID and last flag against the command. Mismatches are reported as `SLVERR` on the offending beat and latched into a sticky error flag.

## Interface
Parameters:
- `CMD_DEPTH`, 2: command queue depth (≥1).
- `ID_WIDTH`, 6: AXI ID width.
- `DATA_WIDTH`, 64: beat width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset; asynchronous, active-low.
- `cmd_valid_i`, in, 1: command valid.
- `cmd_ready_o`, out, 1: command queue not full.
- `cmd_id_i`, in, `ID_WIDTH`: burst ID.
- `cmd_len_i`, in, 8: AXI len; beats = len+1.
- `rd_data_pop_dat_i`, in, `DATA_WIDTH`: beat data.
- `rd_data_pop_gnt_i`, in, 1: beat available (valid).
- `rd_data_pop_req_o`, out, 1: pop beat (ready).
- `rd_data_pop_id_i`, in, `ID_WIDTH`: beat ID.
- `rd_data_pop_last_i`, in, 1: beat last flag.
- `r_valid_o`, out, 1: AXI R valid.
- `r_ready_i`, in, 1: AXI R ready.
- `r_data_o`, out, `DATA_WIDTH`: AXI R data.
- `r_id_o`, out, `ID_WIDTH`: AXI R ID.
- `r_resp_o`, out, 2: AXI R resp.
- `r_last_o`, out, 1: AXI R last.
- `err_o`, out, 1: sticky mismatch flag.
- `err_clr_i`, in, 1: clear `err_o`.

## Operation
- **Command queue**
  - FIFO of {id, len}, `CMD_DEPTH` entries.
  - `cmd_ready_o = !full`.
  - Push on `cmd_valid_i & cmd_ready_o`.
  - When full, a same-cycle pop does not enable a push.
- **FSM states:** `IDLE`, `BURST`.
  - `IDLE`: if the queue is non-empty, pop the head, load `cur_id` and `beats_left = len+1` (9-bit counter), then go to `BURST`.
  - `BURST`: `rd_data_pop_req_o = !r_valid_o | r_ready_i`. In `IDLE`, `rd_data_pop_req_o = 0`.
- **Beat transfer:** `rd_data_pop_req_o & rd_data_pop_gnt_i`. On a transfer:
  - Register data into the output stage: `r_valid_o` ← 1, `r_id_o` ← `cur_id`, `r_last_o` ← (`beats_left == 1`).
  - Decrement `beats_left`.
- **Check:** a beat is in error if `rd_data_pop_id_i != cur_id` or `rd_data_pop_last_i != (beats_left == 1)`.
  - Error beat: `r_resp_o` = `SLVERR` (2'b10) and `err_o` set.
  - Otherwise `r_resp_o` = `OKAY`.
  - The beat is still forwarded; the burst length always follows the command, never `rd_data_pop_last_i`.
- **Last beat transfer:**
  - If the queue is non-empty, pop and reload in the same cycle and stay in `BURST` (no bubble).
  - Otherwise go to `IDLE`.
- **Output stage:** `r_valid_o` clears on `r_valid_o & r_ready_i` with no new transfer. Output holds stable while `r_valid_o & !r_ready_i`.
- **`err_clr_i`:** clears `err_o`. A simultaneous new error wins (`err_o` stays 1).

## Timing
- **Reset values:** `r_valid_o`, `r_last_o`, `r_data_o`, `r_id_o`, `r_resp_o`, `rd_data_pop_req_o`, `err_o` all 0. Queue empty, so `cmd_ready_o` = 1. FSM in `IDLE`.
- **Command to first pop:**
  - Command accepted in cycle 0.
  - Queue non-empty in cycle 1; FSM loads.
  - `BURST` and `rd_data_pop_req_o` = 1 in cycle 2.
- **Beat latency:** a beat transferred in cycle n shows `r_valid_o` in cycle n+1.
- **Throughput:** one beat per cycle with `r_ready_i` held high, including across back-to-back bursts.
- **Backpressure:** `r_ready_i` low with `r_valid_o` high drops `rd_data_pop_req_o` combinationally in the same cycle.
- **Reset mid-burst:** immediate. The queue is flushed, the partial burst is abandoned, and the outputs go to their reset values.

## Structure
- `axi2mem_pkg` holds:
  - `RESP_OKAY` / `RESP_SLVERR` localparams.
  - `r_state_e` enum {`IDLE`, `BURST`}.
  - `r_cmd_t` struct {id, len}.
- The command queue is one instance of the existing `axi2mem_buffer` (`DATA_WIDTH` = `ID_WIDTH`+8, `BUFFER_DEPTH` = `CMD_DEPTH`):
  - push side `valid_i` / `ready_o`
  - pop side `valid_o` / `ready_i`
- The FSM, counter and output register are local logic.

## Test plan
- **Single beat:** cmd id=5, len=0; beat id=5, last=1, data=0x0123456789ABCDEF → one R beat: id 5, last 1, resp `OKAY`, data matches, first `r_valid_o` 3 cycles after cmd accept.
- **Back-to-back bursts:** cmds (id=1, len=3) and (id=2, len=1) queued, beats always valid, `r_ready_i`=1 → 6 consecutive R beats with no gap; `r_last_o` on beats 4 and 6; ids 1,1,1,1,2,2.
- **Backpressure:** toggle `r_ready_i` randomly during a len=7 burst → all 8 beats delivered in order, no loss or duplication, output stable while stalled.
- **Last mismatch:** len=2 with `rd_data_pop_last_i`=1 on beat 2 → beat 2 resp `SLVERR`, `err_o`=1 and stays set, burst still ends on beat 3. `err_clr_i` then clears `err_o`.
- **Queue full:** push 3 cmds with `CMD_DEPTH`=2 and no data → third held until a pop; `cmd_ready_o` = 0 while full.
- **Reset mid-burst:** assert `rst_ni`=0 during beat 2 of len=3 → all outputs 0 asynchronously; after release, a fresh cmd id=7, len=0 completes normally.

Source files
------------

// File: rtl/axi2mem_pkg.sv
// axi2mem_pkg: shared response codes, read-driver state and command types for the axi2mem bridge
package axi2mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned AXI_ID_WIDTH = 6;

    typedef enum logic {IDLE, BURST} r_state_e;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic [7:0]              len;
    } r_cmd_t;

endpackage

// File: rtl/axi2mem_buffer.sv
// axi2mem_buffer: small valid/ready FIFO; ready_o means not full, valid_o means not empty
module axi2mem_buffer #(
    parameter int unsigned DATA_WIDTH   = 14,
    parameter int unsigned BUFFER_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int unsigned PTR_W = BUFFER_DEPTH > 1 ? $clog2(BUFFER_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  push, pop;

    assign ready_o = cnt != CNT_W'(BUFFER_DEPTH);
    assign valid_o = cnt != '0;
    assign data_o  = mem[rd_ptr];
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/axi2mem_r_chan_drv.sv
// axi2mem_r_chan_drv: drives AXI R beats from the read pop interface, framing bursts by command
module axi2mem_r_chan_drv #(
    parameter int unsigned CMD_DEPTH  = 2,
    parameter int unsigned ID_WIDTH   = 6,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ID_WIDTH-1:0]   cmd_id_i,
    input  logic [7:0]            cmd_len_i,
    input  logic [DATA_WIDTH-1:0] rd_data_pop_dat_i,
    input  logic                  rd_data_pop_gnt_i,
    output logic                  rd_data_pop_req_o,
    input  logic [ID_WIDTH-1:0]   rd_data_pop_id_i,
    input  logic                  rd_data_pop_last_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    output logic                  err_o,
    input  logic                  err_clr_i
);

    import axi2mem_pkg::*;

    r_state_e              state, state_nxt;
    logic [ID_WIDTH+7:0]   q_data;
    logic                  q_valid, q_pop;
    logic [ID_WIDTH-1:0]   cur_id;
    logic [8:0]            beats_left;
    logic                  xfer, last_beat, beat_err;

    axi2mem_buffer #(
        .DATA_WIDTH  (ID_WIDTH + 8),
        .BUFFER_DEPTH(CMD_DEPTH)
    ) i_cmd_queue (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .data_i ({cmd_id_i, cmd_len_i}),
        .valid_i(cmd_valid_i),
        .ready_o(cmd_ready_o),
        .data_o (q_data),
        .valid_o(q_valid),
        .ready_i(q_pop)
    );

    assign last_beat = beats_left == 9'd1;
    assign xfer      = rd_data_pop_req_o & rd_data_pop_gnt_i;
    assign beat_err  = (rd_data_pop_id_i != cur_id) || (rd_data_pop_last_i != last_beat);

    // Popping the next command on the last beat keeps back-to-back bursts bubble-free
    always_comb begin
        state_nxt         = state;
        q_pop             = 1'b0;
        rd_data_pop_req_o = 1'b0;
        if (state == IDLE) begin
            q_pop     = q_valid;
            state_nxt = q_valid ? BURST : IDLE;
        end else begin
            rd_data_pop_req_o = !r_valid_o | r_ready_i;
            q_pop             = xfer & last_beat & q_valid;
            state_nxt         = (xfer & last_beat & !q_valid) ? IDLE : BURST;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cur_id     <= '0;
            beats_left <= '0;
        end else begin
            state <= state_nxt;
            if (q_pop) begin
                cur_id     <= q_data[ID_WIDTH+7:8];
                beats_left <= {1'b0, q_data[7:0]} + 9'd1;
            end else if (xfer) begin
                beats_left <= beats_left - 9'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
            r_id_o    <= '0;
            r_resp_o  <= RESP_OKAY;
            r_last_o  <= 1'b0;
        end else if (xfer) begin
            r_valid_o <= 1'b1;
            r_data_o  <= rd_data_pop_dat_i;
            r_id_o    <= cur_id;
            r_resp_o  <= beat_err ? RESP_SLVERR : RESP_OKAY;
            r_last_o  <= last_beat;
        end else if (r_ready_i) begin
            r_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_o <= 1'b0;
        else if (xfer & beat_err) err_o <= 1'b1;
        else if (err_clr_i) err_o <= 1'b0;
    end

endmodule
